// File: rtl/mips_control_unit.sv
// rtl/mips_control_unit.sv - registered main decoder for the single-issue MIPS datapath
//
// Purpose:
//   Decodes instr[31:26] into the datapath control strobes and a 3-bit ALU
//   operation class. All outputs come from flops, so they change only on the
//   rising clock edge (or immediately on reset) and never glitch with opcode.
//
// Ports:
//   clk       in   1  rising-edge clock
//   rst       in   1  asynchronous, active-high reset (all outputs forced to 0)
//   opcode    in   6  instr[31:26]
//   RegDst    out  1  1: write reg = rd, 0: write reg = rt
//   ALUSrc    out  1  1: ALU operand B = sign-extended immediate, 0: rt
//   MemtoReg  out  1  1: write-back from data memory, 0: from ALU
//   RegWrite  out  1  register-file write enable
//   MemRead   out  1  data-memory read enable
//   MemWrite  out  1  data-memory write enable
//   Branch    out  1  conditional-branch enable (ANDed with ALU zero downstream)
//   ALUOp     out  3  operation class for the ALU control block

module mips_control_unit (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  output logic       RegDst,
  output logic       ALUSrc,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       Branch,
  output logic [2:0] ALUOp
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b000001;
  localparam logic [5:0] OP_LW    = 6'b000100;
  localparam logic [5:0] OP_SW    = 6'b000101;
  localparam logic [5:0] OP_BEQ   = 6'b000110;
  localparam logic [5:0] OP_SLTI  = 6'b000111;

  localparam logic [2:0] ALUOP_ADD   = 3'b000;
  localparam logic [2:0] ALUOP_SUB   = 3'b001;
  localparam logic [2:0] ALUOP_FUNCT = 3'b010;
  localparam logic [2:0] ALUOP_ADDI  = 3'b011;
  localparam logic [2:0] ALUOP_SLT   = 3'b100;

  logic       reg_dst_d,   reg_dst_q;
  logic       alu_src_d,   alu_src_q;
  logic       mem_to_reg_d, mem_to_reg_q;
  logic       reg_write_d, reg_write_q;
  logic       mem_read_d,  mem_read_q;
  logic       mem_write_d, mem_write_q;
  logic       branch_d,    branch_q;
  logic [2:0] alu_op_d,    alu_op_q;

  // Everything defaults to the NOP vector; only the listed opcodes raise a
  // strobe. An opcode with unknown bits matches no item and also stays NOP,
  // so no write enable can be raised by an undefined instruction.
  always_comb begin
    reg_dst_d    = 1'b0;
    alu_src_d    = 1'b0;
    mem_to_reg_d = 1'b0;
    reg_write_d  = 1'b0;
    mem_read_d   = 1'b0;
    mem_write_d  = 1'b0;
    branch_d     = 1'b0;
    alu_op_d     = ALUOP_ADD;
    case (opcode)
      OP_RTYPE: begin
        reg_dst_d   = 1'b1;
        reg_write_d = 1'b1;
        alu_op_d    = ALUOP_FUNCT;
      end
      OP_ADDI: begin
        alu_src_d   = 1'b1;
        reg_write_d = 1'b1;
        alu_op_d    = ALUOP_ADDI;
      end
      OP_LW: begin
        alu_src_d    = 1'b1;
        mem_to_reg_d = 1'b1;
        reg_write_d  = 1'b1;
        mem_read_d   = 1'b1;
        alu_op_d     = ALUOP_ADD;
      end
      OP_SW: begin
        alu_src_d   = 1'b1;
        mem_write_d = 1'b1;
        alu_op_d    = ALUOP_ADD;
      end
      OP_BEQ: begin
        branch_d = 1'b1;
        alu_op_d = ALUOP_SUB;
      end
      OP_SLTI: begin
        alu_src_d   = 1'b1;
        reg_write_d = 1'b1;
        alu_op_d    = ALUOP_SLT;
      end
      default: begin
        alu_op_d = ALUOP_ADD;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_dst_q    <= 1'b0;
      alu_src_q    <= 1'b0;
      mem_to_reg_q <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      branch_q     <= 1'b0;
      alu_op_q     <= 3'b000;
    end else begin
      reg_dst_q    <= reg_dst_d;
      alu_src_q    <= alu_src_d;
      mem_to_reg_q <= mem_to_reg_d;
      reg_write_q  <= reg_write_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      branch_q     <= branch_d;
      alu_op_q     <= alu_op_d;
    end
  end

  assign RegDst   = reg_dst_q;
  assign ALUSrc   = alu_src_q;
  assign MemtoReg = mem_to_reg_q;
  assign RegWrite = reg_write_q;
  assign MemRead  = mem_read_q;
  assign MemWrite = mem_write_q;
  assign Branch   = branch_q;
  assign ALUOp    = alu_op_q;

endmodule

// File: tb/tb_mips_control_unit.sv
// tb/tb_mips_control_unit.sv - scoreboard bench for mips_control_unit

module tb_mips_control_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = 6'b000000;
  logic       RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch;
  logic [2:0] ALUOp;

  mips_control_unit dut (
    .clk(clk), .rst(rst), .opcode(opcode),
    .RegDst(RegDst), .ALUSrc(ALUSrc), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .MemRead(MemRead), .MemWrite(MemWrite), .Branch(Branch), .ALUOp(ALUOp)
  );

  always #5 clk = ~clk;

  // {RegDst ALUSrc MemtoReg RegWrite MemRead MemWrite Branch, ALUOp}
  logic [9:0] obs;
  assign obs = {RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, ALUOp};

  logic [9:0] exp_q[$];
  string      name_q[$];
  int         n_vec = 0;
  int         n_err = 0;

  // Reference decode: the instruction table as a plain lookup list.
  function automatic logic [9:0] model(input logic [5:0] op);
    logic [5:0] ops [6];
    logic [9:0] vecs[6];
    ops  = '{6'b000000, 6'b000001, 6'b000100, 6'b000101, 6'b000110, 6'b000111};
    vecs = '{10'b1001000_010, 10'b0101000_011, 10'b0111100_000,
             10'b0100010_000, 10'b0000001_001, 10'b0101000_100};
    for (int i = 0; i < 6; i++)
      if (ops[i] == op) return vecs[i];
    return 10'b0000000_000;
  endfunction

  task automatic chk(input string nm, input logic [9:0] act, input logic [9:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b_%b want %b_%b", nm, act[9:3], act[2:0], exp[9:3], exp[2:0]);
    end
  endtask

  // Issue one opcode just after a rising edge; it is captured on the next edge.
  task automatic issue(input logic [5:0] op, input string nm);
    @(posedge clk);
    #3;
    opcode = op;
    exp_q.push_back(model(op));
    name_q.push_back(nm);
  endtask

  // Monitor: one output per rising edge, compared 1 time unit after the edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        chk(name_q.pop_front(), obs, exp_q.pop_front());
        chk("inv_rd_wr",    {9'b0, ~(MemRead & MemWrite)}, 10'd1);
        chk("inv_regwrite", {9'b0, ~(RegWrite & (MemWrite | Branch))}, 10'd1);
        chk("inv_memtoreg", {9'b0, ~(MemtoReg & ~MemRead)}, 10'd1);
      end
    end
  end

  initial begin
    logic [5:0] legal [6];
    logic [5:0] illegal [3];
    logic [5:0] op;
    legal   = '{6'b000000, 6'b000100, 6'b000101, 6'b000111, 6'b000110, 6'b000001};
    illegal = '{6'b000010, 6'b111111, 6'b100011};

    // Reset held: outputs zero before and across clock edges.
    #1;
    chk("reset_initial", obs, 10'b0);
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("reset_held_edge", obs, 10'b0);
    end

    // Release reset; first decode on the following edge is R-type.
    @(posedge clk);
    #3;
    rst = 1'b0;
    exp_q.push_back(model(opcode));
    name_q.push_back("reset_release_rtype");

    // Full sweep, one opcode per edge.
    foreach (legal[i]) issue(legal[i], $sformatf("sweep_%b", legal[i]));

    // Latency: opcode change mid-cycle must not reach outputs before the edge.
    issue(6'b000000, "latency_rtype");
    @(posedge clk);
    #5;
    opcode = 6'b000101;
    #2;
    chk("latency_hold", obs, model(6'b000000));
    exp_q.push_back(model(6'b000101));
    name_q.push_back("latency_sw");

    // Illegal opcodes decode to NOP.
    foreach (illegal[i]) issue(illegal[i], $sformatf("illegal_%b", illegal[i]));

    // Asynchronous reset pulse between edges during an lw decode.
    issue(6'b000100, "async_lw_decode");
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_immediate", obs, 10'b0);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_released_no_edge", obs, 10'b0);
    exp_q.push_back(model(opcode));
    name_q.push_back("async_recover_lw");

    // Random opcodes, biased half the time toward legal ones.
    for (int k = 0; k < 1000; k++) begin
      if ($urandom_range(0, 1) == 0) op = legal[$urandom_range(0, 5)];
      else                           op = 6'($urandom_range(0, 63));
      issue(op, $sformatf("random_%b", op));
    end

    // Drain with a bounded wait.
    repeat (3) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: %0d outputs never observed, want 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
